// File: rtl/ysyx_23060191_mem_arbiter_pkg.sv
// Shared constants for the IFU/LSU memory arbiter:
// CPU width, FSM state encoding and grant encoding.
package ysyx_23060191_mem_arbiter_pkg;

    localparam int CPU_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } arb_state_e;

    typedef enum logic {
        GNT_IFU = 1'b0,
        GNT_LSU = 1'b1
    } gnt_e;

    // On a tie the requester that did not win last time is served.
    function automatic gnt_e rr_pick(
        input logic ifu_v,
        input logic lsu_v,
        input gnt_e last
    );
        if (ifu_v && lsu_v) begin
            return (last == GNT_LSU) ? GNT_IFU : GNT_LSU;
        end
        return ifu_v ? GNT_IFU : GNT_LSU;
    endfunction

endpackage

// File: rtl/ysyx_23060191_rsp_timer.sv
// Clearable 8-bit saturating cycle counter with a
// compare against TIMEOUT; expired stays high once reached.
module ysyx_23060191_rsp_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    logic [7:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= 8'd0;
        end else if (i_en && (r_cnt != 8'hFF)) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // ">=" keeps the timer armed in WAIT after a handshake
    // that landed exactly on the TIMEOUT cycle.
    assign o_expired = (r_cnt >= 8'(TIMEOUT));

endmodule

// File: rtl/ysyx_23060191_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between
// IFU and LSU, with a bounded wait and error response.
module ysyx_23060191_mem_arbiter
    import ysyx_23060191_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = CPU_WIDTH,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_rsp_valid,
    output logic [DATA_W-1:0] ifu_rsp_data,
    output logic              ifu_rsp_err,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic              lsu_wen,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [3:0]        lsu_wmask,
    output logic              lsu_rsp_valid,
    output logic [DATA_W-1:0] lsu_rsp_data,
    output logic              lsu_rsp_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wmask,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,
    output logic              busy
);

    arb_state_e        r_state;
    arb_state_e        w_next;
    gnt_e              r_last_gnt;
    gnt_e              w_gnt;
    logic              w_accept;
    logic              w_cnt_en;
    logic              w_expired;
    logic              w_rsp_ok;
    logic              w_tmo;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_wen;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [3:0]        r_mem_wmask;
    logic [DATA_W-1:0] r_ifu_data;
    logic              r_ifu_err;
    logic [DATA_W-1:0] r_lsu_data;
    logic              r_lsu_err;

    assign w_gnt    = rr_pick(ifu_req_valid, lsu_req_valid, r_last_gnt);
    assign w_accept = (r_state == ST_IDLE) && !rst
                    && (ifu_req_valid || lsu_req_valid);
    assign w_cnt_en = (r_state == ST_REQ) || (r_state == ST_WAIT);
    assign w_rsp_ok = (r_state == ST_WAIT) && mem_rsp_valid;
    // A handshake in the expiry cycle takes precedence.
    assign w_tmo = w_expired
        && (((r_state == ST_REQ) && !mem_req_ready)
         || ((r_state == ST_WAIT) && !mem_rsp_valid));

    ysyx_23060191_rsp_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_accept),
        .i_en      (w_cnt_en),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: if (w_accept) w_next = ST_REQ;
            ST_REQ: begin
                if (mem_req_ready) w_next = ST_WAIT;
                else if (w_expired) w_next = ST_RESP;
            end
            ST_WAIT: begin
                if (mem_rsp_valid) w_next = ST_RESP;
                else if (w_expired) w_next = ST_RESP;
            end
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        ifu_req_ready = w_accept && (w_gnt == GNT_IFU);
        lsu_req_ready = w_accept && (w_gnt == GNT_LSU);
        mem_req_valid = (r_state == ST_REQ);
        busy          = (r_state != ST_IDLE);
        ifu_rsp_valid = (r_state == ST_RESP)
                      && (r_last_gnt == GNT_IFU);
        lsu_rsp_valid = (r_state == ST_RESP)
                      && (r_last_gnt == GNT_LSU);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_gnt  <= GNT_LSU;
            r_mem_addr  <= '0;
            r_mem_wen   <= 1'b0;
            r_mem_wdata <= '0;
            r_mem_wmask <= 4'b0000;
            r_ifu_data  <= '0;
            r_ifu_err   <= 1'b0;
            r_lsu_data  <= '0;
            r_lsu_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_last_gnt <= w_gnt;
                if (w_gnt == GNT_IFU) begin
                    r_mem_addr  <= ifu_addr;
                    r_mem_wen   <= 1'b0;
                    r_mem_wdata <= '0;
                    r_mem_wmask <= 4'b0000;
                end else begin
                    r_mem_addr  <= lsu_addr;
                    r_mem_wen   <= lsu_wen;
                    r_mem_wdata <= lsu_wdata;
                    r_mem_wmask <= lsu_wmask;
                end
            end
            if (w_rsp_ok || w_tmo) begin
                if (r_last_gnt == GNT_IFU) begin
                    r_ifu_data <= w_rsp_ok ? mem_rsp_data : '0;
                    r_ifu_err  <= !w_rsp_ok;
                end else begin
                    r_lsu_data <= (w_rsp_ok && !r_mem_wen)
                                ? mem_rsp_data : '0;
                    r_lsu_err  <= !w_rsp_ok;
                end
            end
        end
    end

    assign mem_addr     = r_mem_addr;
    assign mem_wen      = r_mem_wen;
    assign mem_wdata    = r_mem_wdata;
    assign mem_wmask    = r_mem_wmask;
    assign ifu_rsp_data = r_ifu_data;
    assign ifu_rsp_err  = r_ifu_err;
    assign lsu_rsp_data = r_lsu_data;
    assign lsu_rsp_err  = r_lsu_err;

endmodule

// File: tb/tb_ysyx_23060191_mem_arbiter.sv
// Bench for the memory arbiter: memory responder process
// plus a transaction-level model of grants, latency, data.
module tb_ysyx_23060191_mem_arbiter;

    localparam int T = 8;

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } req_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ifu_req_valid = 1'b0;
    logic        ifu_req_ready;
    logic [31:0] ifu_addr = '0;
    logic        ifu_rsp_valid;
    logic [31:0] ifu_rsp_data;
    logic        ifu_rsp_err;
    logic        lsu_req_valid = 1'b0;
    logic        lsu_req_ready;
    logic [31:0] lsu_addr = '0;
    logic        lsu_wen = 1'b0;
    logic [31:0] lsu_wdata = '0;
    logic [3:0]  lsu_wmask = '0;
    logic        lsu_rsp_valid;
    logic [31:0] lsu_rsp_data;
    logic        lsu_rsp_err;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = '0;
    logic        busy;

    ysyx_23060191_mem_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (T)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_addr      (ifu_addr),
        .ifu_rsp_valid (ifu_rsp_valid),
        .ifu_rsp_data  (ifu_rsp_data),
        .ifu_rsp_err   (ifu_rsp_err),
        .lsu_req_valid (lsu_req_valid),
        .lsu_req_ready (lsu_req_ready),
        .lsu_addr      (lsu_addr),
        .lsu_wen       (lsu_wen),
        .lsu_wdata     (lsu_wdata),
        .lsu_wmask     (lsu_wmask),
        .lsu_rsp_valid (lsu_rsp_valid),
        .lsu_rsp_data  (lsu_rsp_data),
        .lsu_rsp_err   (lsu_rsp_err),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_wen       (mem_wen),
        .mem_wdata     (mem_wdata),
        .mem_wmask     (mem_wmask),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    // requester queues and per-requester state: 0 idle, 1 valid, 2 outstanding
    req_t ifu_q[$];
    req_t lsu_q[$];
    int   ifu_st = 0, lsu_st = 0;
    int   ifu_wait = 0, lsu_wait = 0;

    // transaction-level model
    bit          m_busy = 0;
    int          m_rsp_cyc = -1;
    bit          m_g = 0;
    bit          m_last = 1;
    logic [31:0] m_data = '0;
    bit          m_err = 0;

    // memory behaviour knobs: ready after r REQ cycles, respond d cycles after
    int          kr = 0, kd = 0;
    bit          krand = 0;
    int          bfm_r = 0, bfm_d = 0;
    logic [31:0] e_addr = '0, e_wdata = '0;
    logic        e_wen = 1'b0;
    logic [3:0]  e_wmask = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0010_0073;
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // memory responder
    logic b_rst_s = 1'b0;
    int   b_rc = 0, b_dc = 0;
    bit   b_hs = 0, b_in = 0;
    always @(posedge clk) begin
        b_rst_s = rst;
        #1;
        mem_rsp_valid = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_data  = $urandom;
        if (b_rst_s) begin
            b_rc = 0; b_dc = 0; b_hs = 0; b_in = 0;
        end else begin
            if (b_hs) begin
                b_hs = 0; b_in = 1; b_dc = 0;
            end
            if (mem_req_valid) b_in = 0;
            if (b_in) begin
                if (b_dc == bfm_d) begin
                    mem_rsp_valid = 1'b1;
                    mem_rsp_data  = mem_word(mem_addr);
                    b_in = 0;
                end else begin
                    b_dc++;
                end
            end
            if (mem_req_valid) begin
                chk("mem_addr", mem_addr, e_addr);
                chk("mem_wen", 32'(mem_wen), 32'(e_wen));
                chk("mem_wmask", 32'(mem_wmask), 32'(e_wmask));
                if (e_wen) chk("mem_wdata", mem_wdata, e_wdata);
                if (b_rc == bfm_r) begin
                    mem_req_ready = 1'b1;
                    b_hs = 1; b_rc = 0;
                end else begin
                    b_rc++;
                end
            end else begin
                b_rc = 0;
            end
        end
    end

    task automatic wait_edge;
        @(posedge clk);
        #1;
    endtask

    task automatic check_cycle;
        bit at_rsp;
        if (m_busy && cyc > m_rsp_cyc) m_busy = 0;
        at_rsp = m_busy && (cyc == m_rsp_cyc);
        chk("busy", 32'(busy), 32'(m_busy));
        chk("ifu_rsp_valid", 32'(ifu_rsp_valid), 32'(at_rsp && !m_g));
        chk("lsu_rsp_valid", 32'(lsu_rsp_valid), 32'(at_rsp && m_g));
        if (at_rsp) begin
            if (!m_g) begin
                chk("ifu_rsp_data", ifu_rsp_data, m_data);
                chk("ifu_rsp_err", 32'(ifu_rsp_err), 32'(m_err));
                ifu_st = 0;
            end else begin
                chk("lsu_rsp_data", lsu_rsp_data, m_data);
                chk("lsu_rsp_err", 32'(lsu_rsp_err), 32'(m_err));
                lsu_st = 0;
            end
        end
    endtask

    task automatic drive;
        req_t q;
        if (ifu_st != 1) ifu_req_valid = 1'b0;
        if (ifu_st == 0 && ifu_q.size() > 0) begin
            q = ifu_q.pop_front();
            ifu_addr = q.addr; ifu_req_valid = 1'b1;
            ifu_st = 1; ifu_wait = 0;
        end
        if (lsu_st != 1) lsu_req_valid = 1'b0;
        if (lsu_st == 0 && lsu_q.size() > 0) begin
            q = lsu_q.pop_front();
            lsu_addr = q.addr; lsu_wen = q.wen;
            lsu_wdata = q.wdata; lsu_wmask = q.wmask;
            lsu_req_valid = 1'b1;
            lsu_st = 1; lsu_wait = 0;
        end
    endtask

    task automatic accept(input bit g);
        int r, d, lat;
        bit err;
        if (krand) begin
            r = ($urandom_range(0, 9) == 9) ? 9 : int'($urandom_range(0, 3));
            d = ($urandom_range(0, 7) == 0) ? 12 : int'($urandom_range(0, 2));
        end else begin
            r = kr; d = kd;
        end
        bfm_r = r; bfm_d = d;
        if (!g) begin
            e_addr = ifu_addr; e_wen = 1'b0;
            e_wdata = '0; e_wmask = 4'b0000;
            chk("ifu_wait_bound", 32'(ifu_wait <= 1), 32'd1);
            ifu_st = 2;
            if (lsu_st == 1) lsu_wait++;
        end else begin
            e_addr = lsu_addr; e_wen = lsu_wen;
            e_wdata = lsu_wdata; e_wmask = lsu_wmask;
            chk("lsu_wait_bound", 32'(lsu_wait <= 1), 32'd1);
            lsu_st = 2;
            if (ifu_st == 1) ifu_wait++;
        end
        err = (r > T) || (d >= 1 && r + d >= T);
        if (r > T) lat = T + 2;
        else if (err) lat = ((r + 1 > T) ? r + 1 : T) + 2;
        else lat = r + d + 3;
        m_last = g; m_g = g; m_busy = 1; m_err = err;
        m_data = (err || e_wen) ? 32'h0 : mem_word(e_addr);
        m_rsp_cyc = cyc + lat;
    endtask

    task automatic post;
        bit iv, lv, g;
        #1;
        iv = ifu_req_valid; lv = lsu_req_valid;
        g = (iv && lv) ? !m_last : !iv;
        chk("ifu_req_ready", 32'(ifu_req_ready), 32'(!m_busy && (iv || lv) && !g));
        chk("lsu_req_ready", 32'(lsu_req_ready), 32'(!m_busy && (iv || lv) && g));
        if (!m_busy && (iv || lv)) accept(g);
    endtask

    task automatic step;
        wait_edge;
        check_cycle;
        drive;
        post;
    endtask

    task automatic run(input int n);
        repeat (n) step;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        wait_edge;
        rst = 1'b0;
        m_busy = 0; m_last = 1;
        if (ifu_st == 2) ifu_st = 0;
        if (lsu_st == 2) lsu_st = 0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ifu_rsp_valid", 32'(ifu_rsp_valid), 32'd0);
        chk("rst_lsu_rsp_valid", 32'(lsu_rsp_valid), 32'd0);
        chk("rst_ifu_rsp_err", 32'(ifu_rsp_err), 32'd0);
        chk("rst_lsu_rsp_err", 32'(lsu_rsp_err), 32'd0);
        chk("rst_ifu_rsp_data", ifu_rsp_data, 32'd0);
        chk("rst_lsu_rsp_data", lsu_rsp_data, 32'd0);
        chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wen", 32'(mem_wen), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_wmask", 32'(mem_wmask), 32'd0);
        drive;
        post;
    endtask

    function automatic req_t mk(input logic [31:0] a, input logic w,
                                input logic [31:0] d, input logic [3:0] m);
        req_t q;
        q.addr = a; q.wen = w; q.wdata = d; q.wmask = m;
        return q;
    endfunction

    initial begin
        repeat (2) @(posedge clk);
        do_reset;

        // plain fetch, minimum latency
        ifu_q.push_back(mk(32'h8000_0000, 1'b0, '0, '0));
        run(6);

        // tie after reset: IFU first, then the store
        do_reset;
        ifu_q.push_back(mk(32'h8000_0004, 1'b0, '0, '0));
        lsu_q.push_back(mk(32'h8000_0100, 1'b1, 32'hDEAD_BEEF, 4'b1111));
        run(10);

        // memory stalls the request for 5 cycles
        kr = 5;
        lsu_q.push_back(mk(32'h8000_0200, 1'b0, 32'h1234_5678, 4'b0011));
        run(12);
        kr = 0;

        // memory answers too late: error, late strobe ignored
        kd = 11;
        lsu_q.push_back(mk(32'h8000_0300, 1'b0, '0, 4'b1111));
        run(18);
        kd = 0;

        // handshake exactly on the timeout cycle wins
        kr = T;
        ifu_q.push_back(mk(32'h8000_0008, 1'b0, '0, '0));
        run(16);
        kr = 0;

        // reset while a load waits for memory
        kd = 20;
        lsu_q.push_back(mk(32'h8000_0400, 1'b0, '0, 4'b1111));
        run(3);
        do_reset;
        kd = 0;
        ifu_q.push_back(mk(32'h8000_000C, 1'b0, '0, '0));
        lsu_q.push_back(mk(32'h8000_0404, 1'b0, '0, 4'b1111));
        run(10);

        // continuous traffic from both sides
        for (int i = 0; i < 4; i++) begin
            ifu_q.push_back(mk(32'h8000_1000 + 32'(4 * i), 1'b0, '0, '0));
            lsu_q.push_back(mk(32'h8000_2000 + 32'(4 * i), 1'(i & 1),
                               $urandom, 4'(i + 1)));
        end
        run(40);

        // randomized traffic and memory timing
        krand = 1;
        for (int i = 0; i < 300; i++) begin
            if (ifu_q.size() == 0 && $urandom_range(0, 2) != 0)
                ifu_q.push_back(mk({$urandom} & 32'hFFFF_FFFC, 1'b0, '0, '0));
            if (lsu_q.size() == 0 && $urandom_range(0, 2) != 0)
                lsu_q.push_back(mk({$urandom} & 32'hFFFF_FFFC, 1'($urandom),
                                   $urandom, 4'($urandom)));
            step;
        end
        krand = 0;
        run(30);
        chk("drained", 32'(ifu_q.size() + lsu_q.size() + ifu_st + lsu_st), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
